// File: rtl/telemetry_pkg.sv
// Shared constants and state types for the telemetry receiver.
package telemetry_pkg;

  localparam logic [7:0]  SYNC_BYTE1  = 8'hAA;
  localparam logic [7:0]  SYNC_BYTE2  = 8'h55;
  localparam int unsigned PAYLOAD_LEN = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    SYNC1   = 2'd0,
    SYNC2   = 2'd1,
    PAYLOAD = 2'd2
  } pkt_state_t;

endpackage

// File: rtl/telemetry_rx_uart_rx.sv
// 8N1 UART receiver: RX synchroniser, mid-bit sampling byte FSM, baud counter.
module uart_rx
  import telemetry_pkg::*;
#(
  parameter int unsigned BAUD_CNT = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       byte_rdy,
  output logic       frm_err,
  output logic       rx_busy
);

  localparam int unsigned CNT_W = $clog2(BAUD_CNT + 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(BAUD_CNT / 2);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(BAUD_CNT);

  logic             rx_meta, rx_sync, rx_prev;
  rx_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic [7:0]       rx_data_nxt;
  logic             byte_rdy_nxt, frm_err_nxt;
  logic             fall_c, tick_c;

  assign fall_c  = rx_prev & ~rx_sync;
  assign tick_c  = (cnt == CNT_W'(1));
  assign rx_busy = (state != IDLE);

  // Two-flop synchroniser plus edge-detect flop; line idles high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Next-state: start qualify at half bit, then sample every bit period.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bit_idx_nxt  = bit_idx;
    shreg_nxt    = shreg;
    rx_data_nxt  = rx_data;
    byte_rdy_nxt = 1'b0;
    frm_err_nxt  = 1'b0;
    if (state != IDLE && !tick_c) cnt_nxt = cnt - CNT_W'(1);
    case (state)
      IDLE: begin
        if (fall_c) begin
          state_nxt = START;
          cnt_nxt   = HALF_BIT;
        end
      end
      START: begin
        if (tick_c) begin
          if (rx_sync) begin
            state_nxt = IDLE;
          end else begin
            state_nxt   = DATA;
            cnt_nxt     = FULL_BIT;
            bit_idx_nxt = 3'd0;
          end
        end
      end
      DATA: begin
        if (tick_c) begin
          shreg_nxt = {rx_sync, shreg[7:1]};
          cnt_nxt   = FULL_BIT;
          if (bit_idx == 3'd7) state_nxt = STOP;
          else bit_idx_nxt = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (tick_c) begin
          state_nxt = IDLE;
          if (rx_sync) begin
            byte_rdy_nxt = 1'b1;
            rx_data_nxt  = shreg;
          end else begin
            frm_err_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Byte FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      rx_data  <= '0;
      byte_rdy <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      shreg    <= shreg_nxt;
      rx_data  <= rx_data_nxt;
      byte_rdy <= byte_rdy_nxt;
      frm_err  <= frm_err_nxt;
    end
  end

endmodule

// File: rtl/telemetry_rx.sv
// Telemetry packet receiver: byte stream -> sync hunt, payload parse, field outputs.
module telemetry_rx
  import telemetry_pkg::*;
#(
  parameter int unsigned BAUD_CNT = 2604,
  parameter int unsigned GAP_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic [11:0] batt_v,
  output logic [11:0] avg_curr,
  output logic [11:0] avg_torque,
  output logic        pkt_vld,
  output logic        frm_err,
  output logic [7:0]  pkt_err_cnt
);

  localparam int unsigned GAP_LIMIT = GAP_BITS * BAUD_CNT;
  localparam int unsigned GAP_W     = $clog2(GAP_LIMIT + 1);

  logic [7:0]       rx_data;
  logic             byte_rdy, rx_busy;
  pkt_state_t       pstate, pstate_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [3:0]       hi_nib, hi_nib_nxt;
  logic [11:0]      stg_batt, stg_batt_nxt, stg_curr, stg_curr_nxt;
  logic [11:0]      batt_nxt, curr_nxt, torque_nxt;
  logic             pkt_vld_nxt;
  logic [7:0]       err_cnt_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic             hi_bad_c, timeout_c, abort_c;

  uart_rx #(.BAUD_CNT(BAUD_CNT)) u_uart (
    .clk      (clk),
    .rst_n    (rst_n),
    .RX       (RX),
    .rx_data  (rx_data),
    .byte_rdy (byte_rdy),
    .frm_err  (frm_err),
    .rx_busy  (rx_busy)
  );

  // Gap time counts only while the line is idle, so it measures idle between bytes.
  assign hi_bad_c  = !idx[0] && (rx_data[7:4] != 4'h0);
  assign timeout_c = (pstate == PAYLOAD) && (gap_cnt == GAP_W'(GAP_LIMIT));
  assign abort_c   = (pstate == PAYLOAD) &&
                     (frm_err || (byte_rdy && hi_bad_c) || (timeout_c && !byte_rdy));

  // Next-state: sync hunt, payload staging, abort accounting.
  always_comb begin
    pstate_nxt   = pstate;
    idx_nxt      = idx;
    hi_nib_nxt   = hi_nib;
    stg_batt_nxt = stg_batt;
    stg_curr_nxt = stg_curr;
    batt_nxt     = batt_v;
    curr_nxt     = avg_curr;
    torque_nxt   = avg_torque;
    pkt_vld_nxt  = 1'b0;
    err_cnt_nxt  = pkt_err_cnt;
    gap_nxt      = gap_cnt;
    if (pstate != PAYLOAD || byte_rdy) gap_nxt = '0;
    else if (!rx_busy && !timeout_c) gap_nxt = gap_cnt + GAP_W'(1);
    case (pstate)
      SYNC1: begin
        if (byte_rdy && rx_data == SYNC_BYTE1) pstate_nxt = SYNC2;
      end
      SYNC2: begin
        if (byte_rdy) begin
          if (rx_data == SYNC_BYTE2) begin
            pstate_nxt = PAYLOAD;
            idx_nxt    = 3'd0;
          end else if (rx_data != SYNC_BYTE1) begin
            pstate_nxt = SYNC1;
          end
        end
      end
      PAYLOAD: begin
        if (abort_c) begin
          pstate_nxt = SYNC1;
          if (pkt_err_cnt != 8'hFF) err_cnt_nxt = pkt_err_cnt + 8'd1;
        end else if (byte_rdy) begin
          idx_nxt = idx + 3'd1;
          case (idx)
            3'd0, 3'd2, 3'd4: hi_nib_nxt = rx_data[3:0];
            3'd1:             stg_batt_nxt = {hi_nib, rx_data};
            3'd3:             stg_curr_nxt = {hi_nib, rx_data};
            default:          ;
          endcase
          if (idx == 3'(PAYLOAD_LEN - 1)) begin
            batt_nxt    = stg_batt;
            curr_nxt    = stg_curr;
            torque_nxt  = {hi_nib, rx_data};
            pkt_vld_nxt = 1'b1;
            pstate_nxt  = SYNC1;
          end
        end
      end
      default: pstate_nxt = SYNC1;
    endcase
  end

  // Packet FSM state, staging and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pstate      <= SYNC1;
      idx         <= '0;
      hi_nib      <= '0;
      stg_batt    <= '0;
      stg_curr    <= '0;
      batt_v      <= '0;
      avg_curr    <= '0;
      avg_torque  <= '0;
      pkt_vld     <= 1'b0;
      pkt_err_cnt <= '0;
      gap_cnt     <= '0;
    end else begin
      pstate      <= pstate_nxt;
      idx         <= idx_nxt;
      hi_nib      <= hi_nib_nxt;
      stg_batt    <= stg_batt_nxt;
      stg_curr    <= stg_curr_nxt;
      batt_v      <= batt_nxt;
      avg_curr    <= curr_nxt;
      avg_torque  <= torque_nxt;
      pkt_vld     <= pkt_vld_nxt;
      pkt_err_cnt <= err_cnt_nxt;
      gap_cnt     <= gap_nxt;
    end
  end

endmodule

// File: tb/tb_telemetry_rx.sv
// Bench for telemetry_rx: serial byte driver, packet-level reference model, directed + random steps.
module tb_telemetry_rx;
  import telemetry_pkg::*;

  localparam int unsigned B = 16;
  localparam int unsigned G = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RX;
  logic [11:0] batt_v, avg_curr, avg_torque;
  logic        pkt_vld, frm_err;
  logic [7:0]  pkt_err_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // Observed event counts
  int cyc = 0, last_rdy = -10, obs_bytes = 0, obs_vld = 0, obs_frm = 0, obs_lat_bad = 0;

  // Reference model state: 0 = hunting 0xAA, 1 = expecting 0x55, 2 = collecting payload
  int          m_st = 0;
  logic [7:0]  m_q[$];
  logic [11:0] m_batt = '0, m_curr = '0, m_torque = '0;
  int          m_err = 0, m_vld = 0, m_frm = 0, m_bytes = 0;

  telemetry_rx #(.BAUD_CNT(B), .GAP_BITS(G)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .batt_v      (batt_v),
    .avg_curr    (avg_curr),
    .avg_torque  (avg_torque),
    .pkt_vld     (pkt_vld),
    .frm_err     (frm_err),
    .pkt_err_cnt (pkt_err_cnt)
  );

  always #5 clk = ~clk;

  // Event monitor, sampled on the falling edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (pkt_vld) begin
      obs_vld = obs_vld + 1;
      if (last_rdy != cyc - 1) obs_lat_bad = obs_lat_bad + 1;
    end
    if (dut.u_uart.byte_rdy) begin
      obs_bytes = obs_bytes + 1;
      last_rdy  = cyc;
    end
    if (frm_err) obs_frm = obs_frm + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_batt"},   32'(batt_v),      32'(m_batt));
    check({tag, "_curr"},   32'(avg_curr),    32'(m_curr));
    check({tag, "_torque"}, 32'(avg_torque),  32'(m_torque));
    check({tag, "_errcnt"}, 32'(pkt_err_cnt), 32'(m_err));
    check({tag, "_nvld"},   32'(obs_vld),     32'(m_vld));
    check({tag, "_nfrm"},   32'(obs_frm),     32'(m_frm));
    check({tag, "_nbytes"}, 32'(obs_bytes),   32'(m_bytes));
    check({tag, "_vldlat"}, 32'(obs_lat_bad), 32'd0);
  endtask

  // Model: abort of an in-progress payload
  task automatic m_abort();
    m_st = 0;
    if (m_err < 255) m_err++;
  endtask

  // Model: one correctly framed byte
  task automatic m_byte(input logic [7:0] b);
    m_bytes++;
    case (m_st)
      0: if (b == 8'hAA) m_st = 1;
      1: begin
        if (b == 8'h55) begin
          m_st = 2;
          m_q.delete();
        end else if (b != 8'hAA) begin
          m_st = 0;
        end
      end
      default: begin
        if ((m_q.size() % 2 == 0) && (b[7:4] != 4'h0)) begin
          m_abort();
        end else begin
          m_q.push_back(b);
          if (m_q.size() == 6) begin
            m_batt   = {m_q[0][3:0], m_q[1]};
            m_curr   = {m_q[2][3:0], m_q[3]};
            m_torque = {m_q[4][3:0], m_q[5]};
            m_vld++;
            m_st = 0;
          end
        end
      end
    endcase
  endtask

  task automatic m_frame_err();
    m_frm++;
    if (m_st == 2) m_abort();
  endtask

  // Idle of 17+ bit periods inside a payload exceeds the gap limit; 15 or fewer does not
  task automatic m_idle(input int bits);
    if (bits >= 17 && m_st == 2) m_abort();
  endtask

  task automatic drive_bit(input logic v);
    RX = v;
    repeat (B) @(negedge clk);
  endtask

  task automatic idle(input int bits);
    RX = 1'b1;
    repeat (bits * B) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  // One byte on the wire, then idle, mirrored into the model
  task automatic xfer(input logic [7:0] b, input logic stop, input int idle_bits);
    send_byte(b, stop);
    if (stop) m_byte(b);
    else m_frame_err();
    idle(idle_bits);
    m_idle(idle_bits);
  endtask

  task automatic send_seq(input logic [7:0] s[], input int frm_at, input int gap_at, input int gap_bits);
    for (int j = 0; j < s.size(); j++)
      xfer(s[j], (j != frm_at), (j == gap_at) ? gap_bits : 1);
  endtask

  task automatic m_reset();
    m_st = 0; m_batt = '0; m_curr = '0; m_torque = '0; m_err = 0;
  endtask

  initial begin
    logic [7:0] seq[];
    RX    = 1'b1;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_batt",   32'(batt_v),      32'd0);
    check("rst_errcnt", 32'(pkt_err_cnt), 32'd0);
    check("rst_vld",    32'(pkt_vld),     32'd0);
    check("rst_sync",   32'(dut.u_uart.rx_sync), 32'd1);
    rst_n = 1'b1;
    idle(2);
    check_all("rst");

    // Good packet
    seq = '{8'hAA, 8'h55, 8'h0A, 8'h98, 8'h01, 8'h23, 8'h07, 8'hFF};
    send_seq(seq, -1, -1, 0);
    check("good_batt",   32'(batt_v),     32'hA98);
    check("good_curr",   32'(avg_curr),   32'h123);
    check("good_torque", 32'(avg_torque), 32'h7FF);
    check_all("good");

    // Resync through noise and repeated 0xAA
    seq = '{8'h12, 8'hAA, 8'hAA, 8'h55, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
    send_seq(seq, -1, -1, 0);
    check("resync_batt",   32'(batt_v),     32'h001);
    check("resync_torque", 32'(avg_torque), 32'h003);
    check_all("resync");

    // Bad hi nibble aborts, fields hold, next packet decodes
    seq = '{8'hAA, 8'h55, 8'h1A, 8'h98, 8'h01, 8'h23, 8'h07, 8'hFF};
    send_seq(seq, -1, -1, 0);
    check("nib_errcnt", 32'(pkt_err_cnt), 32'd1);
    check("nib_curr",   32'(avg_curr),    32'h002);
    check_all("nibble");
    seq = '{8'hAA, 8'h55, 8'h03, 8'h21, 8'h04, 8'h56, 8'h0F, 8'h00};
    send_seq(seq, -1, -1, 0);
    check_all("after_nib");

    // Framing error on a payload byte
    seq = '{8'hAA, 8'h55, 8'h0A, 8'h98, 8'h01, 8'h23, 8'h07, 8'hFF};
    send_seq(seq, 3, -1, 0);
    check("frm_errcnt", 32'(pkt_err_cnt), 32'd2);
    check_all("framing");

    // Gap timeout at 17 idle bits, tolerated at 15
    send_seq(seq, -1, 2, 17);
    check("gap17_errcnt", 32'(pkt_err_cnt), 32'd3);
    check_all("gap17");
    send_seq(seq, -1, 2, 15);
    check("gap15_batt", 32'(batt_v), 32'hA98);
    check_all("gap15");

    // Short low glitch produces no byte
    RX = 1'b0;
    repeat (B / 4) @(negedge clk);
    idle(3);
    check_all("glitch");

    // Reset in the middle of a packet and a byte
    seq = '{8'hAA, 8'h55, 8'h0B};
    send_seq(seq, -1, -1, 0);
    RX = 1'b0;
    repeat (2 * B) @(negedge clk);
    RX    = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    @(negedge clk);
    check("mrst_pstate", 32'(dut.pstate),         32'(SYNC1));
    check("mrst_ustate", 32'(dut.u_uart.state),   32'(IDLE));
    check("mrst_batt",   32'(batt_v),             32'd0);
    idle(2);
    check_all("midrst");
    seq = '{8'hAA, 8'h55, 8'h0C, 8'h34, 8'h00, 8'h56, 8'h08, 8'h9A};
    send_seq(seq, -1, -1, 0);
    check_all("post_rst");

    // Randomized packets with random faults
    for (int it = 0; it < 12; it++) begin
      int kind, bad_at, frm_at, gap_at;
      logic [7:0] pk[8];
      kind   = int'($urandom_range(0, 4));
      bad_at = (kind == 1) ? 2 * int'($urandom_range(1, 3)) : -1;
      frm_at = (kind == 2) ? int'($urandom_range(2, 7)) : -1;
      gap_at = (kind == 3) ? int'($urandom_range(2, 6)) : -1;
      pk[0] = 8'hAA;
      pk[1] = 8'h55;
      for (int j = 2; j < 8; j++)
        pk[j] = (j % 2 == 0) ? {4'h0, 4'($urandom)} : 8'($urandom);
      if (bad_at >= 0) pk[bad_at][7:4] = 4'($urandom_range(1, 15));
      if (kind == 4)
        repeat ($urandom_range(1, 3)) xfer(8'($urandom), 1'b1, int'($urandom_range(0, 2)));
      for (int j = 0; j < 8; j++)
        xfer(pk[j], (j != frm_at),
             (j == gap_at) ? int'($urandom_range(17, 19)) :
             (j == frm_at) ? 1 : int'($urandom_range(1, 2)));
      check_all($sformatf("rnd%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
